// File: rtl/multi_digit_counter_if.sv
// Control and observation bundle for the cascaded-digit counter.
// The master drives the controls; the counter itself takes the slave side.
interface multi_digit_counter_if #(
    parameter int DIGITS = 6,
    parameter int BASE   = 10
);
    localparam int DW = ($clog2(BASE) < 1) ? 1 : $clog2(BASE);

    logic                 ena;
    logic                 up;
    logic                 wrap;
    logic                 clr;
    logic                 load;
    logic [DIGITS*DW-1:0] load_val;
    logic [DIGITS*DW-1:0] count_out;
    logic                 at_zero;
    logic                 at_max;
    logic                 ovf;

    modport master (
        output ena, up, wrap, clr, load, load_val,
        input  count_out, at_zero, at_max, ovf
    );

    modport slave (
        input  ena, up, wrap, clr, load, load_val,
        output count_out, at_zero, at_max, ovf
    );
endinterface

// File: rtl/multi_digit_counter.sv
// Cascaded radix-BASE up/down counter with wrap/saturate boundary handling.
// The whole ripple resolves combinationally, so every step takes one clock.
module multi_digit_counter #(
    parameter int DIGITS = 6,
    parameter int BASE   = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    multi_digit_counter_if.slave          bus
);
    localparam int DW = ($clog2(BASE) < 1) ? 1 : $clog2(BASE);
    localparam logic [DW-1:0] MAXD = DW'(BASE - 1);

    logic [DIGITS-1:0][DW-1:0] cnt_q, cnt_d;
    logic [DIGITS-1:0][DW-1:0] step_val;
    logic [DIGITS-1:0][DW-1:0] ld_val;
    logic [DIGITS-1:0]         is_max;
    logic [DIGITS-1:0]         is_zero;
    // cin[i]: every digit below i sits at its turnover value for this direction
    logic [DIGITS:0]           cin;
    logic                      ovf_q, ovf_d;
    logic                      boundary;

    assign cin[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [DW-1:0] d;
        logic [DW-1:0] ld_raw;

        assign d          = cnt_q[i];
        assign ld_raw     = bus.load_val[i*DW +: DW];
        assign is_max[i]  = (d == MAXD);
        assign is_zero[i] = (d == '0);

        assign step_val[i] = bus.up ? (is_max[i]  ? '0   : d + DW'(1))
                                    : (is_zero[i] ? MAXD : d - DW'(1));

        // Out-of-range load digits clamp to the top digit value
        assign ld_val[i] = (ld_raw > MAXD) ? MAXD : ld_raw;

        assign cin[i+1] = cin[i] & (bus.up ? is_max[i] : is_zero[i]);
    end

    // A carry/borrow out of the top digit is the boundary crossing
    assign boundary = cin[DIGITS];

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (bus.load) begin
            cnt_d = ld_val;
        end else if (bus.ena) begin
            ovf_d = boundary;
            if (bus.wrap || !boundary) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (cin[i]) cnt_d[i] = step_val[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.count_out = cnt_q;
    assign bus.at_zero   = &is_zero;
    assign bus.at_max    = &is_max;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_multi_digit_counter.sv
// Scoreboard bench: a 4-digit decimal counter checked against an integer
// model, plus a 1-digit binary instance exercised with a toggling enable.
module tb_multi_digit_counter;
    localparam int D    = 4;
    localparam int B    = 10;
    localparam int MAXV = 9999;

    typedef struct packed {
        logic [15:0] cnt;
        logic        az;
        logic        am;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_digit_counter_if #(.DIGITS(D), .BASE(B)) bus ();
    multi_digit_counter_if #(.DIGITS(1), .BASE(2)) bus2 ();

    multi_digit_counter #(.DIGITS(D), .BASE(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    multi_digit_counter #(.DIGITS(1), .BASE(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   mv     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_digits(input int v);
        logic [15:0] r;
        int          pw;
        r  = '0;
        pw = 1;
        for (int k = 0; k < D; k++) begin
            r[k*4 +: 4] = 4'((v / pw) % B);
            pw = pw * B;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [15:0] lv);
        int v;
        int pw;
        int dg;
        v  = 0;
        pw = 1;
        for (int k = 0; k < D; k++) begin
            dg = int'(lv[k*4 +: 4]);
            if (dg >= B) dg = B - 1;
            v  = v + dg * pw;
            pw = pw * B;
        end
        return v;
    endfunction

    // Drive one cycle of controls now and queue what the counter must show after the next edge
    task automatic drive_and_push(input logic ena, input logic up, input logic wrap,
                                  input logic clr, input logic load, input logic [15:0] lv);
        exp_t e;
        logic eo;
        bus.ena = ena; bus.up = up; bus.wrap = wrap;
        bus.clr = clr; bus.load = load; bus.load_val = lv;
        eo = 1'b0;
        if (clr) begin
            mv = 0;
        end else if (load) begin
            mv = from_load(lv);
        end else if (ena) begin
            if (up) begin
                if (mv == MAXV) begin eo = 1'b1; if (wrap) mv = 0; end
                else mv = mv + 1;
            end else begin
                if (mv == 0) begin eo = 1'b1; if (wrap) mv = MAXV; end
                else mv = mv - 1;
            end
        end
        e.cnt = to_digits(mv);
        e.az  = (mv == 0);
        e.am  = (mv == MAXV);
        e.ovf = eo;
        q.push_back(e);
    endtask

    task automatic step(input logic ena, input logic up, input logic wrap,
                        input logic clr, input logic load, input logic [15:0] lv);
        @(negedge clk);
        drive_and_push(ena, up, wrap, clr, load, lv);
    endtask

    // Monitor: the counter presents a fresh output every clock
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count_out", 32'(bus.count_out), 32'(e.cnt));
                chk("at_zero",   32'(bus.at_zero),   32'(e.az));
                chk("at_max",    32'(bus.at_max),    32'(e.am));
                chk("ovf",       32'(bus.ovf),       32'(e.ovf));
            end
        end
    end

    initial begin
        logic [15:0] lv;
        int          v2;
        logic        e2o;
        logic        en2;

        bus.ena = 0; bus.up = 0; bus.wrap = 0; bus.clr = 0; bus.load = 0; bus.load_val = '0;
        bus2.ena = 0; bus2.up = 1; bus2.wrap = 1; bus2.clr = 0; bus2.load = 0; bus2.load_val = '0;

        #1;
        chk("reset count",   32'(bus.count_out), 32'h0);
        chk("reset at_zero", 32'(bus.at_zero),   32'h1);
        chk("reset at_max",  32'(bus.at_max),    32'h0);
        chk("reset ovf",     32'(bus.ovf),       32'h0);
        chk("reset2 count",  32'(bus2.count_out), 32'h0);

        // Full decimal walk with wrap; first step lands on the first edge after release
        @(negedge clk);
        rst = 1'b1;
        drive_and_push(1, 1, 1, 0, 0, '0);
        for (int i = 1; i < 10000; i++) step(1, 1, 1, 0, 0, '0);

        // Saturating count-down from 0003
        step(0, 0, 0, 0, 1, 16'h0003);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, '0);

        // Out-of-range load digits clamp, then step
        step(0, 1, 1, 0, 1, 16'hF3C1);
        step(1, 1, 1, 0, 0, '0);

        // Priority: clr over load over ena
        step(0, 1, 1, 0, 1, 16'h0999);
        step(1, 1, 1, 1, 1, 16'h0500);
        step(1, 1, 1, 0, 1, 16'h0500);

        // Asynchronous reset mid-cycle while a step is pending
        step(0, 1, 1, 0, 1, 16'h9998);
        @(posedge clk);
        #2;
        bus.ena = 1; bus.up = 1; bus.wrap = 1; bus.load = 0; bus.clr = 0;
        #1;
        rst = 1'b0;
        mv  = 0;
        #1;
        chk("async rst count",   32'(bus.count_out), 32'h0);
        chk("async rst at_zero", 32'(bus.at_zero),   32'h1);
        chk("async rst ovf",     32'(bus.ovf),       32'h0);
        @(posedge clk);
        #2;
        chk("held rst count", 32'(bus.count_out), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive_and_push(1, 1, 1, 0, 0, '0);

        // Randomized mix, biased toward the boundaries
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 7))
                0: lv = 16'h9999;
                1: lv = 16'h0000;
                2: lv = 16'h9998;
                3: lv = 16'h0001;
                default: lv = 16'($urandom);
            endcase
            step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), lv);
        end
        @(negedge clk);
        bus.ena = 0; bus.clr = 0; bus.load = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(q.size()), 32'h0);

        // Single binary digit, enable toggling
        v2 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            en2 = (i % 2 == 0);
            bus2.ena = en2;
            e2o = 1'b0;
            if (en2) begin
                if (v2 == 1) begin v2 = 0; e2o = 1'b1; end
                else v2 = 1;
            end
            @(posedge clk);
            #1;
            chk("b2 count", 32'(bus2.count_out), 32'(v2));
            chk("b2 ovf",   32'(bus2.ovf),       32'(e2o));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
